// File: rtl/bp_axil_stream_fifo_bridge.sv
// AXI4-Lite slave that pushes host DATA writes into a word FIFO feeding a valid/ready stream,
// with STATUS (empty/full/occupancy) and a clearable pushed-word counter for host flow control.
module bp_axil_stream_fifo_bridge #(
  parameter int unsigned s_axil_addr_width_p = 32,
  parameter int unsigned stream_data_width_p = 32,
  parameter int unsigned fifo_els_p          = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [s_axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [stream_data_width_p-1:0] s_axil_wdata_i,
  input  logic [3:0]                     s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [s_axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [stream_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i
);

  localparam int unsigned DW   = stream_data_width_p;
  localparam int unsigned PtrW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned CntW = $clog2(fifo_els_p + 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    RegData     = 2'd0,
    RegStatus   = 2'd1,
    RegPushCnt  = 2'd2,
    RegUnmapped = 2'd3
  } reg_e;

  logic            live_q;
  logic [DW-1:0]   mem_q [fifo_els_p];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pushcnt_q, pushcnt_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  reg_e          wr_sel, rd_sel;
  logic          full, empty, strb_ok;
  logic          wr_acc, rd_acc, push, pop;
  logic [DW-1:0] status_word;

  always_comb begin
    wr_sel  = reg_e'(s_axil_awaddr_i[3:2]);
    rd_sel  = reg_e'(s_axil_araddr_i[3:2]);
    empty   = (count_q == '0);
    full    = (count_q == CntW'(fifo_els_p));
    strb_ok = (s_axil_wstrb_i == 4'hF);
    // AW and W are only ever taken together; a full FIFO stalls DATA writes rather than dropping.
    wr_acc  = live_q & s_axil_awvalid_i & s_axil_wvalid_i & ~bvalid_q
              & ~((wr_sel == RegData) & full);
    rd_acc  = live_q & s_axil_arvalid_i & ~rvalid_q;
    push    = wr_acc & (wr_sel == RegData) & strb_ok;
    pop     = ~empty & stream_ready_i;

    status_word        = '0;
    status_word[0]     = empty;
    status_word[1]     = full;
    status_word[31:16] = 16'(count_q);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pushcnt_d = pushcnt_q;
    if (push) begin
      wr_ptr_d  = (wr_ptr_q == PtrW'(fifo_els_p - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      pushcnt_d = pushcnt_q + 32'd1;
    end else if (wr_acc && (wr_sel == RegPushCnt)) begin
      pushcnt_d = '0;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(fifo_els_p - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      unique case (wr_sel)
        RegData:     bresp_d = strb_ok ? RespOkay : RespSlvErr;
        RegUnmapped: bresp_d = RespSlvErr;
        default:     bresp_d = RespOkay;
      endcase
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = RespOkay;
      unique case (rd_sel)
        RegData:    rdata_d = '0;
        RegStatus:  rdata_d = status_word;
        RegPushCnt: rdata_d = DW'(pushcnt_q);
        default: begin
          rdata_d = '0;
          rresp_d = RespSlvErr;
        end
      endcase
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // live_q keeps all handshake outputs low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pushcnt_q <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pushcnt_q <= pushcnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axil_wdata_i;
    end
  end

  assign s_axil_awready_o = wr_acc;
  assign s_axil_wready_o  = wr_acc;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = live_q & ~rvalid_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;
  assign stream_v_o       = ~empty;
  assign stream_data_o    = mem_q[rd_ptr_q];

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i,
                       s_axil_awaddr_i[s_axil_addr_width_p-1:4], s_axil_awaddr_i[1:0],
                       s_axil_araddr_i[s_axil_addr_width_p-1:4], s_axil_araddr_i[1:0]};

endmodule

// File: tb/tb_bp_axil_stream_fifo_bridge.sv
// Directed/randomised bench for bp_axil_stream_fifo_bridge against a queue-based register model.
module tb_bp_axil_stream_fifo_bridge;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] awaddr, wdata, araddr, rdata, stream_data;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, stream_v, stream_ready;
  logic [1:0]  bresp, rresp;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] pcnt_m;
  logic [1:0]  exp_bresp;
  int          npops;

  always #5 clk = ~clk;

  bp_axil_stream_fifo_bridge #(
    .s_axil_addr_width_p(32),
    .stream_data_width_p(32),
    .fifo_els_p         (Depth)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (awprot),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (arprot),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .stream_v_o      (stream_v),
    .stream_data_o   (stream_data),
    .stream_ready_i  (stream_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream side of the model: every pop must match the oldest outstanding pushed word.
  always @(posedge clk) begin
    if (reset_n && stream_v && stream_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL stream_extra: observed word %h expected no word", stream_data);
      end
      if (q.size() != 0) begin
        chk("stream_data", stream_data, q.pop_front());
        npops++;
      end
    end
  end

  always @(negedge clk) chk("stream_v", 32'(stream_v), 32'(q.size() != 0));

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    exp_bresp = 2'b00;
    case (a[3:2])
      2'd0: if (s == 4'hF) begin q.push_back(d); pcnt_m = pcnt_m + 32'd1; end
            else exp_bresp = 2'b10;
      2'd2: pcnt_m = '0;
      2'd3: exp_bresp = 2'b10;
      default: ;
    endcase
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    r = 2'b00;
    d = '0;
    case (a[3:2])
      2'd1: d = {16'(q.size()), 14'b0, q.size() == Depth, q.size() == 0};
      2'd2: d = pcnt_m;
      2'd3: r = 2'b10;
      default: ;
    endcase
  endfunction

  task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic accept_wr(input bit pop_same, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    while (waited < 300) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
      waited++;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL aw_accept: observed no accept expected accept within 300 cycles");
    end
    if (pop_same) stream_ready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (pop_same) stream_ready = 1'b0;
    if (ok) model_write(awaddr, wdata, wstrb);
  endtask

  task automatic finish_wr(input string tag);
    @(negedge clk);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), 32'(exp_bresp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input string tag);
    int w;
    start_wr(a, d, s);
    accept_wr(1'b0, w);
    finish_wr(tag);
  endtask

  task automatic do_rd(input logic [31:0] a, input string tag, output logic [31:0] rd);
    logic [31:0] ed;
    logic [1:0]  er;
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
      n++;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s_ar_accept: observed no accept expected accept", tag);
    end
    model_read(a, ed, er);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, 32'(rresp), 32'(er));
    rd = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain: observed %0d words left expected 0", tag, q.size());
    end
  endtask

  initial begin
    logic [31:0] rd;
    int w;
    reset_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0; araddr = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0; stream_ready = 1'b0;
    pcnt_m = '0; npops = 0; exp_bresp = 2'b00;

    // Reset: outputs held low even with valids asserted, and for the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_arready", 32'(arready), 32'd0);
    chk("rel_awready", 32'(awready), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    chk("live_arready", 32'(arready), 32'd1);

    // 1: single DATA write streams out exactly once.
    stream_ready = 1'b1;
    do_wr(32'h0, 32'h1122_3344, 4'hF, "t1");
    wait_empty("t1");
    chk("t1_npops", 32'(npops), 32'd1);

    // 2: fill to full, 17th write stalls, then drain everything in order.
    stream_ready = 1'b0;
    do_wr(32'h8, $urandom, 4'hF, "t2_clr");
    for (int i = 0; i < Depth; i++) do_wr(32'h0, $urandom, 4'hF, "t2_fill");
    start_wr(32'h0, $urandom, 4'hF);
    repeat (4) begin
      @(negedge clk);
      chk("t2_stall_awready", 32'(awready), 32'd0);
    end
    do_rd(32'h4, "t2_status", rd);
    chk("t2_status_const", rd, 32'h0010_0002);
    stream_ready = 1'b1;
    accept_wr(1'b0, w);
    finish_wr("t2_17th");
    wait_empty("t2");
    do_rd(32'h8, "t2_pushcnt", rd);
    chk("t2_pushcnt_const", rd, 32'd17);

    // 3: error responses.
    stream_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_wr(32'h0, $urandom, 4'hF, "t3_fill");
    do_wr(32'h0, $urandom, 4'h3, "t3_strb");
    do_wr(32'hC, $urandom, 4'hF, "t3_unmapped_wr");
    do_wr(32'h4, $urandom, 4'hF, "t3_status_wr");
    do_rd(32'h4, "t3_status", rd);
    chk("t3_status_const", rd, 32'h0003_0000);
    do_rd(32'hC, "t3_unmapped_rd", rd);
    do_rd(32'h0, "t3_data_rd", rd);
    stream_ready = 1'b1;
    wait_empty("t3");

    // 4: B held by bready=0 blocks the next write until the cycle after the handshake.
    start_wr(32'h0, $urandom, 4'hF);
    accept_wr(1'b0, w);
    awaddr = 32'h0; wdata = $urandom; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_bvalid", 32'(bvalid), 32'd1);
      chk("t4_hold_bresp", 32'(bresp), 32'd0);
      chk("t4_hold_awready", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("t4_bvalid_drop", 32'(bvalid), 32'd0);
    accept_wr(1'b0, w);
    chk("t4_next_wait", 32'(w), 32'd0);
    finish_wr("t4_second");
    wait_empty("t4");

    // 5: push and pop on the same edge at occupancy 5, wrapping the pointers.
    stream_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_wr(32'h0, $urandom, 4'hF, "t5_fill");
    for (int i = 0; i < 20; i++) begin
      start_wr(32'h0, $urandom, 4'hF);
      accept_wr(1'b1, w);
      finish_wr("t5_pp");
      if (i == 10) do_rd(32'h4, "t5_mid_status", rd);
    end
    do_rd(32'h4, "t5_status", rd);
    chk("t5_status_const", rd, 32'h0005_0000);
    stream_ready = 1'b1;
    wait_empty("t5");

    // 6: asynchronous reset mid-drain with a pending B.
    stream_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_wr(32'h0, $urandom, 4'hF, "t6_fill");
    stream_ready = 1'b1;
    start_wr(32'h0, $urandom, 4'hF);
    accept_wr(1'b0, w);
    @(negedge clk);
    chk("t6_pre_bvalid", 32'(bvalid), 32'd1);
    #2;
    reset_n = 1'b0;
    q.delete();
    pcnt_m = '0;
    #1;
    chk("t6_bvalid", 32'(bvalid), 32'd0);
    chk("t6_stream_v", 32'(stream_v), 32'd0);
    chk("t6_arready", 32'(arready), 32'd0);
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_rd(32'h4, "t6_status", rd);
    chk("t6_status_const", rd, 32'h0000_0001);
    do_rd(32'h8, "t6_pushcnt", rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
